// File: rtl/join_buffered.sv
// join_buffered: N-input valid/bp join with a one-entry capture slot per input.
// An early input is captured and held until the slowest input arrives. The joined
// token is then emitted with zero latency. Each input refills its slot in the same
// cycle its held token is consumed.
// Optional macro JOIN_BUFFERED_OUTPUT_REG_EN adds a one-entry output register.
// With that register, dout/dout_valid come only from flops and see one cycle of latency.
module join_buffered #(
  parameter int Width     = 8,
  parameter int NumInputs = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NumInputs*Width-1:0]     din,
  input  logic [NumInputs-1:0]           din_valid,
  output logic [NumInputs-1:0]           din_bp,
  output logic [NumInputs*Width-1:0]     dout,
  output logic                           dout_valid,
  input  logic                           dout_bp
);

  logic [NumInputs-1:0]             captured_q, captured_d;
  logic [NumInputs-1:0][Width-1:0]  slot_q, slot_d;
  logic [NumInputs-1:0]             present;
  logic [NumInputs-1:0][Width-1:0]  joined;
  logic                             all_present;
  logic                             fire;

  // Per input: a token is present if held in the slot or offered now; slot data wins.
  always_comb begin
    present = '0;
    joined  = '0;
    for (int i = 0; i < NumInputs; i++) begin
      present[i] = captured_q[i] | din_valid[i];
      joined[i]  = captured_q[i] ? slot_q[i] : din[i*Width +: Width];
    end
  end

  assign all_present = &present;

  // A held slot blocks its input, unless that held token leaves this cycle.
  assign din_bp = captured_q & {NumInputs{~fire}};

  // Slot update: consume on fire, refill from a concurrently offered token.
  always_comb begin
    captured_d = captured_q;
    slot_d     = slot_q;
    for (int i = 0; i < NumInputs; i++) begin
      if (fire) begin
        if (captured_q[i] && din_valid[i]) begin
          slot_d[i]     = din[i*Width +: Width];
          captured_d[i] = 1'b1;
        end else begin
          captured_d[i] = 1'b0;
        end
      end else if (!captured_q[i] && din_valid[i]) begin
        slot_d[i]     = din[i*Width +: Width];
        captured_d[i] = 1'b1;
      end
    end
  end

  // Capture flags reset; slot data needs no reset because it is only read when captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      captured_q <= '0;
    end else begin
      captured_q <= captured_d;
    end
    slot_q <= slot_d;
  end

`ifdef JOIN_BUFFERED_OUTPUT_REG_EN
  logic                             out_full_q, out_full_d;
  logic [NumInputs-1:0][Width-1:0]  out_data_q, out_data_d;

  // Load the output register when it is empty or draining this cycle.
  assign fire = all_present & (~out_full_q | ~dout_bp);

  // Output register next state: load on fire, otherwise empty when drained.
  always_comb begin
    out_full_d = out_full_q;
    out_data_d = out_data_q;
    if (fire) begin
      out_full_d = 1'b1;
      out_data_d = joined;
    end else if (!dout_bp) begin
      out_full_d = 1'b0;
    end
  end

  // Output register flops; data is qualified by out_full and needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_full_q <= 1'b0;
    end else begin
      out_full_q <= out_full_d;
    end
    out_data_q <= out_data_d;
  end

  assign dout       = out_data_q;
  assign dout_valid = out_full_q;
`else
  assign fire       = all_present & ~dout_bp;
  assign dout       = joined;
  assign dout_valid = all_present;
`endif

endmodule

// File: tb/tb_join_buffered.sv
// Directed bench for join_buffered (Width=8, NumInputs=3).
// Define JOIN_BUFFERED_OUTPUT_REG_EN to exercise the registered-output build instead.
module tb_join_buffered;

  localparam int Width     = 8;
  localparam int NumInputs = 3;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [NumInputs*Width-1:0]   din;
  logic [NumInputs-1:0]         din_valid;
  logic [NumInputs-1:0]         din_bp;
  logic [NumInputs*Width-1:0]   dout;
  logic                         dout_valid;
  logic                         dout_bp;

  int checks   = 0;
  int failures = 0;

  join_buffered #(.Width(Width), .NumInputs(NumInputs)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_bp     (din_bp),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_bp    (dout_bp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs, then wait until mid-cycle, where outputs are sampled.
  task automatic drive(input logic [2:0] v, input logic [7:0] d2, input logic [7:0] d1,
                       input logic [7:0] d0, input logic bp);
    din_valid = v;
    din       = {d2, d1, d0};
    dout_bp   = bp;
    #3;
  endtask

  initial begin
    reset = 1'b1;
    din_valid = '0;
    din = '0;
    dout_bp = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    #3;
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_din_bp", 32'(din_bp), 32'h0);
    cyc();

`ifndef JOIN_BUFFERED_OUTPUT_REG_EN
    // Test 1: all inputs arrive together.
    drive(3'b111, 8'hCC, 8'hBB, 8'hAA, 1'b0);
    chk("t1_valid", 32'(dout_valid), 32'h1);
    chk("t1_dout", 32'(dout), 32'hCCBBAA);
    chk("t1_bp", 32'(din_bp), 32'h0);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t1_after_bp", 32'(din_bp), 32'h0);
    chk("t1_after_valid", 32'(dout_valid), 32'h0);
    cyc();

    // Test 2: staggered arrivals.
    drive(3'b001, 8'h00, 8'h00, 8'h11, 1'b0);
    chk("t2_c0_bp", 32'(din_bp), 32'h0);
    chk("t2_c0_valid", 32'(dout_valid), 32'h0);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t2_c1_bp", 32'(din_bp), 32'h1);
    chk("t2_c1_valid", 32'(dout_valid), 32'h0);
    cyc();
    drive(3'b010, 8'h00, 8'h22, 8'h00, 1'b0);
    chk("t2_c2_bp", 32'(din_bp), 32'h1);
    chk("t2_c2_valid", 32'(dout_valid), 32'h0);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t2_c3_bp", 32'(din_bp), 32'h3);
    chk("t2_c3_valid", 32'(dout_valid), 32'h0);
    cyc();
    drive(3'b100, 8'h33, 8'h00, 8'h00, 1'b0);
    chk("t2_c4_valid", 32'(dout_valid), 32'h1);
    chk("t2_c4_dout", 32'(dout), 32'h332211);
    chk("t2_c4_bp", 32'(din_bp), 32'h0);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t2_c5_bp", 32'(din_bp), 32'h0);
    chk("t2_c5_valid", 32'(dout_valid), 32'h0);
    cyc();

    // Test 3: all captured under backpressure, then a single release.
    drive(3'b111, 8'h03, 8'h02, 8'h01, 1'b1);
    chk("t3_c0_valid", 32'(dout_valid), 32'h1);
    chk("t3_c0_bp", 32'(din_bp), 32'h0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      drive(3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b1);
      chk("t3_hold_valid", 32'(dout_valid), 32'h1);
      chk("t3_hold_dout", 32'(dout), 32'h030201);
      chk("t3_hold_bp", 32'(din_bp), 32'h7);
      cyc();
    end
    drive(3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    chk("t3_rel_valid", 32'(dout_valid), 32'h1);
    chk("t3_rel_dout", 32'(dout), 32'h030201);
    chk("t3_rel_bp", 32'(din_bp), 32'h0);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t3_post_valid", 32'(dout_valid), 32'h0);
    chk("t3_post_bp", 32'(din_bp), 32'h0);
    cyc();

    // Test 4: in0 refills its slot in the fire cycle.
    drive(3'b001, 8'h00, 8'h00, 8'h01, 1'b0);
    cyc();
    drive(3'b111, 8'h66, 8'h55, 8'h02, 1'b0);
    chk("t4_fire_valid", 32'(dout_valid), 32'h1);
    chk("t4_fire_dout", 32'(dout), 32'h665501);
    chk("t4_fire_bp", 32'(din_bp), 32'h0);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t4_next_bp", 32'(din_bp), 32'h1);
    chk("t4_next_valid", 32'(dout_valid), 32'h0);
    cyc();
    drive(3'b110, 8'h88, 8'h77, 8'hEE, 1'b0);
    chk("t4_second_valid", 32'(dout_valid), 32'h1);
    chk("t4_second_dout", 32'(dout), 32'h887702);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t4_end_bp", 32'(din_bp), 32'h0);
    cyc();

    // Test 5: reset discards a partial set.
    drive(3'b011, 8'h00, 8'hB2, 8'hB1, 1'b0);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t5_pre_bp", 32'(din_bp), 32'h3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t5_rst_bp", 32'(din_bp), 32'h0);
    chk("t5_rst_valid", 32'(dout_valid), 32'h0);
    cyc();
    drive(3'b100, 8'hC3, 8'h00, 8'h00, 1'b0);
    chk("t5_partial_valid", 32'(dout_valid), 32'h0);
    cyc();
    drive(3'b011, 8'h00, 8'hC2, 8'hC1, 1'b0);
    chk("t5_fresh_valid", 32'(dout_valid), 32'h1);
    chk("t5_fresh_dout", 32'(dout), 32'hC3C2C1);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t5_end_valid", 32'(dout_valid), 32'h0);
    chk("t5_end_bp", 32'(din_bp), 32'h0);
    cyc();
`else
    // Test 6: registered output, continuous stream, then one held token under bp.
    for (int k = 0; k < 4; k++) begin
      drive(3'b111, 8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k), 1'b0);
      if (k == 0) begin
        chk("t6_c0_valid", 32'(dout_valid), 32'h0);
      end else begin
        chk("t6_stream_valid", 32'(dout_valid), 32'h1);
        chk("t6_stream_dout", 32'(dout), {8'h00, 8'(8'h30 + k - 1), 8'(8'h20 + k - 1), 8'(8'h10 + k - 1)});
      end
      chk("t6_stream_bp", 32'(din_bp), 32'h0);
      cyc();
    end
    drive(3'b111, 8'h34, 8'h24, 8'h14, 1'b1);
    chk("t6_bp0_valid", 32'(dout_valid), 32'h1);
    chk("t6_bp0_dout", 32'(dout), 32'h332313);
    chk("t6_bp0_bp", 32'(din_bp), 32'h0);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("t6_bp1_valid", 32'(dout_valid), 32'h1);
    chk("t6_bp1_dout", 32'(dout), 32'h332313);
    chk("t6_bp1_bp", 32'(din_bp), 32'h7);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t6_rel_dout", 32'(dout), 32'h332313);
    chk("t6_rel_bp", 32'(din_bp), 32'h0);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t6_last_valid", 32'(dout_valid), 32'h1);
    chk("t6_last_dout", 32'(dout), 32'h342414);
    cyc();
    drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t6_empty_valid", 32'(dout_valid), 32'h0);
    cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
